multi_channel_dac_sequencer: RTL and testbench
==============================================

// Module: multi_channel_dac_sequencer
// PURPOSE
//  Next-generation sample-to-DAC sequencer. On each sample strobe it captures NUM_CHANNELS signed samples.
//  It converts each to an unsigned DAC code (offset, negative clamp, scale, saturate) on one shared datapath.
//  It then sends the codes one after another through the existing DAC SPI serializer handshake (data/send/ready).
//  Sits between the additive mixer and the DAC SPI output block; replaces the fixed two-channel output stage.
// PARAMETERS
//  NUM_CHANNELS   2           channels per frame, 1..8; channel n sent with command CMD_BASE+n
//  SAMPLE_WIDTH   32          width of each signed input sample
//  DAC_BITS       16          DAC code width; full scale = 2^DAC_BITS-1
//  SAMPLE_OFFSET  'h1FFFF     signed offset added before scaling (bipolar -> unipolar)
//  SHIFT          2           arithmetic right shift applied after offset
//  CMD_BASE       8'b00110001 DAC command byte for channel 0
//  LDAC_CYCLES    4           LDAC low pulse length in clocks (used only with DAC_LDAC_EN)
// PORTS
//  i_Clock         in   1                          system clock
//  i_Reset         in   1                          asynchronous, active-low reset
//  i_Start         in   1                          one-cycle frame strobe
//  i_Samples       in   NUM_CHANNELS*SAMPLE_WIDTH  signed samples; ch n = [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//  i_Clip_Clear    in   1                          clears sticky clip flags
//  i_DAC_Ready     in   1                          serializer idle
//  o_DAC_Data      out  8+DAC_BITS                 {command byte, code} to serializer
//  o_DAC_Send      out  1                          send request to serializer
//  o_LDAC          out  1                          DAC latch, active low (held 1 without DAC_LDAC_EN)
//  o_Busy          out  1                          frame in progress (state != IDLE)
//  o_Frame_Done    out  1                          one-cycle pulse after the last channel completes
//  o_Dropped       out  1                          one-cycle pulse: i_Start ignored
//  o_Clip          out  NUM_CHANNELS               sticky per-channel saturation flags
// BEHAVIOUR
//  Reset (i_Reset=0, async): state IDLE, channel index 0, all outputs 0 except o_LDAC=1; sample regs 0.
//  States:
//   IDLE -> CONVERT: on i_Start && i_DAC_Ready. Latches the whole i_Samples bus and sets ch=0.
//   CONVERT: s = sext(sample[ch], SAMPLE_WIDTH+1) + SAMPLE_OFFSET.
//     Code = 0 if s<0. Otherwise t = s>>>SHIFT; code = 2^DAC_BITS-1 if t > 2^DAC_BITS-1, else t.
//     Saturation sets o_Clip[ch]. -> SEND.
//   SEND: o_DAC_Data={CMD_BASE+ch, code}; o_DAC_Send=1 -> ACK.
//   ACK: hold o_DAC_Send=1 until i_DAC_Ready=0, then o_DAC_Send=0 -> DRAIN.
//   DRAIN: wait until i_DAC_Ready=1. Then ch<NUM_CHANNELS-1: ch++ -> CONVERT. Else -> LDAC (if enabled) or DONE.
//   DONE: o_Frame_Done=1 for one cycle -> IDLE.
//  o_DAC_Data is stable from SEND until the next SEND.
//  o_DAC_Send never rises while i_DAC_Ready=0.
//  Minimum frame time per channel: 3 clocks + serializer time. Plus 1 clock for DONE.
//  i_Start while not IDLE, or in IDLE with i_DAC_Ready=0: o_Dropped pulses the next cycle.
//    The frame in progress is unaffected and the strobe is not queued.
//  Samples are latched at frame start; i_Samples changes during the frame have no effect.
//  o_Clip: set wins over i_Clip_Clear in the same cycle. Clear otherwise takes effect the next cycle.
//  Reset mid-frame: the frame is abandoned immediately and o_DAC_Send drops asynchronously.
//  Offset and limit arithmetic never overflows: the sum is SAMPLE_WIDTH+1 bits wide.
// CONFIGURATION
//  DAC_LDAC_EN defined:
//   After the last DRAIN, state LDAC drives o_LDAC=0 for exactly LDAC_CYCLES clocks, then -> DONE.
//   All channels update simultaneously.
//  DAC_LDAC_EN undefined: no LDAC state, o_LDAC tied 1, DRAIN goes straight to DONE.
// TESTING (NUM_CHANNELS=2, defaults; model serializer: ready drops 1 clk after send, returns 10 clks later)
//  ch0=0, ch1=0 -> words 0x317FFF then 0x327FFF; o_Frame_Done once; o_Clip=00.
//  ch0=-0x20000 (s=-1), ch1=0x20000 -> codes 0x0000, 0xFFFF; o_Clip=00 (exact full scale is not a clip).
//  ch1=0x20001 -> code 0xFFFF, o_Clip=10.
//    Then i_Clip_Clear -> o_Clip=00.
//    Clear on the same cycle as a new clip -> flag stays set.
//  i_Start pulsed while sending ch0 -> o_Dropped 1 cycle; exactly 2 words sent; next start accepted after DONE.
//  Assert i_Reset=0 during ACK of ch1 -> o_DAC_Send=0, o_Busy=0 at once.
//    After release, a new start sends ch0 first.
//  DAC_LDAC_EN build -> o_LDAC low 4 clks after 2nd ready return, before o_Frame_Done; o_LDAC=1 throughout otherwise.

Source files
------------

// File: rtl/multi_channel_dac_sequencer.sv
// rtl/multi_channel_dac_sequencer.sv - frame sequencer: signed samples -> DAC codes -> serializer handshake
// Optional macro DAC_LDAC_EN adds a simultaneous-update LDAC low pulse after the last channel.
module multi_channel_dac_sequencer #(
  parameter int         NUM_CHANNELS  = 2,
  parameter int         SAMPLE_WIDTH  = 32,
  parameter int         DAC_BITS      = 16,
  parameter int         SAMPLE_OFFSET = 'h1FFFF,
  parameter int         SHIFT         = 2,
  parameter logic [7:0] CMD_BASE      = 8'b00110001,
  parameter int         LDAC_CYCLES   = 4
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic                               i_Start,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_Samples,
  input  logic                               i_Clip_Clear,
  input  logic                               i_DAC_Ready,
  output logic [8+DAC_BITS-1:0]              o_DAC_Data,
  output logic                               o_DAC_Send,
  output logic                               o_LDAC,
  output logic                               o_Busy,
  output logic                               o_Frame_Done,
  output logic                               o_Dropped,
  output logic [NUM_CHANNELS-1:0]            o_Clip
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);
  localparam logic signed [SAMPLE_WIDTH:0] OFFSET_EXT = (SAMPLE_WIDTH+1)'(SAMPLE_OFFSET);
  localparam logic signed [SAMPLE_WIDTH:0] FULL_SCALE =
    {{(SAMPLE_WIDTH+1-DAC_BITS){1'b0}}, {DAC_BITS{1'b1}}};

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || LDAC_CYCLES < 1) begin : g_bad_params
    $error("multi_channel_dac_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SEND    = 3'd2,
    S_ACK     = 3'd3,
    S_DRAIN   = 3'd4,
`ifdef DAC_LDAC_EN
    S_LDAC    = 3'd6,
`endif
    S_DONE    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [SAMPLE_WIDTH-1:0]     sample_q [NUM_CHANNELS];
  logic [CH_W-1:0]             ch;
  logic [8+DAC_BITS-1:0]       dac_data;
  logic [NUM_CHANNELS-1:0]     clip, clip_set;
  logic                        dropped;
  logic [SAMPLE_WIDTH-1:0]     cur_sample;
  logic signed [SAMPLE_WIDTH:0] sum, shifted;
  logic [DAC_BITS-1:0]         code;
  logic                        sat;

`ifdef DAC_LDAC_EN
  localparam int LC_W = $clog2(LDAC_CYCLES + 1);
  localparam logic [LC_W-1:0] LDAC_LAST = LC_W'(LDAC_CYCLES - 1);
  logic [LC_W-1:0] ldac_cnt;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset)            ldac_cnt <= '0;
    else if (state == S_LDAC) ldac_cnt <= ldac_cnt + LC_W'(1);
    else                     ldac_cnt <= '0;
  end
`endif

  // One shared converter: the sum is one bit wider than a sample so the offset cannot wrap.
  always_comb begin
    cur_sample = sample_q[ch];
    sum        = $signed({cur_sample[SAMPLE_WIDTH-1], cur_sample}) + OFFSET_EXT;
    shifted    = sum >>> SHIFT;
    code       = shifted[DAC_BITS-1:0];
    sat        = 1'b0;
    clip_set   = '0;
    if (sum[SAMPLE_WIDTH]) begin
      code = '0;
    end else if (shifted > FULL_SCALE) begin
      code = '1;
      sat  = 1'b1;
    end
    if (state == S_CONVERT && sat) clip_set[ch] = 1'b1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    o_DAC_Send   = 1'b0;
    o_Busy       = (state != S_IDLE);
    o_Frame_Done = 1'b0;
    o_LDAC       = 1'b1;
    case (state)
      S_IDLE:    if (i_Start && i_DAC_Ready) next_state = S_CONVERT;
      S_CONVERT: next_state = S_SEND;
      S_SEND: begin
        o_DAC_Send = 1'b1;
        next_state = S_ACK;
      end
      S_ACK: begin
        o_DAC_Send = 1'b1;
        if (!i_DAC_Ready) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_DAC_Ready) begin
          if (ch != LAST_CH) next_state = S_CONVERT;
`ifdef DAC_LDAC_EN
          else               next_state = S_LDAC;
`else
          else               next_state = S_DONE;
`endif
        end
      end
`ifdef DAC_LDAC_EN
      S_LDAC: begin
        o_LDAC = 1'b0;
        if (ldac_cnt == LDAC_LAST) next_state = S_DONE;
      end
`endif
      S_DONE: begin
        o_Frame_Done = 1'b1;
        next_state   = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      ch       <= '0;
      dac_data <= '0;
      clip     <= '0;
      dropped  <= 1'b0;
      for (int n = 0; n < NUM_CHANNELS; n++) sample_q[n] <= '0;
    end else begin
      dropped <= i_Start && !(state == S_IDLE && i_DAC_Ready);
      // A saturation in the same cycle as a clear keeps its flag.
      clip    <= (i_Clip_Clear ? '0 : clip) | clip_set;
      if (state == S_IDLE && i_Start && i_DAC_Ready) begin
        ch <= '0;
        for (int n = 0; n < NUM_CHANNELS; n++)
          sample_q[n] <= i_Samples[n*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
      if (state == S_CONVERT) dac_data <= {CMD_BASE + 8'(ch), code};
      if (state == S_DRAIN && i_DAC_Ready && ch != LAST_CH) ch <= ch + CH_W'(1);
    end
  end

  assign o_DAC_Data = dac_data;
  assign o_Dropped  = dropped;
  assign o_Clip     = clip;

endmodule

// File: tb/tb_multi_channel_dac_sequencer.sv
// tb/tb_multi_channel_dac_sequencer.sv - directed bench for multi_channel_dac_sequencer with a serializer model
module tb_multi_channel_dac_sequencer;
  localparam int NCH = 2;
  localparam int SW  = 32;
  localparam int DB  = 16;
`ifdef DAC_LDAC_EN
  localparam int LDAC_EXP = 4;
`else
  localparam int LDAC_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic clip_clear = 1'b0;
  logic ready = 1'b1;
  logic [NCH*SW-1:0] samples = '0;
  logic [8+DB-1:0] dac_data;
  logic dac_send, ldac, busy, frame_done, dropped;
  logic [NCH-1:0] clip;

  logic [23:0] words[$];
  int ser_cnt = 0;
  int frames = 0;
  int drops = 0;
  int ldac_lows = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_dac_sequencer dut (
    .i_Clock      (clk),
    .i_Reset      (rst_n),
    .i_Start      (start),
    .i_Samples    (samples),
    .i_Clip_Clear (clip_clear),
    .i_DAC_Ready  (ready),
    .o_DAC_Data   (dac_data),
    .o_DAC_Send   (dac_send),
    .o_LDAC       (ldac),
    .o_Busy       (busy),
    .o_Frame_Done (frame_done),
    .o_Dropped    (dropped),
    .o_Clip       (clip)
  );

  // Serializer model: takes the word and drops ready half a clock after send, ready returns 10 clocks later.
  always @(negedge clk) begin
    if (frame_done) frames++;
    if (dropped) drops++;
    if (!ldac) ldac_lows++;
    if (ready) begin
      if (dac_send) begin
        words.push_back(dac_data);
        ready = 1'b0;
        ser_cnt = 10;
      end
    end else begin
      ser_cnt--;
      if (ser_cnt == 0) ready = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin tick(); n++; end
  endtask

  task automatic run_frame(input logic [31:0] s0, input logic [31:0] s1, input bit inject_drop,
                           output logic [23:0] w0, output logic [23:0] w1);
    int fbase, wbase, dbase, lbase, n;
    fbase = frames; wbase = words.size(); dbase = drops; lbase = ldac_lows;
    wait_ready();
    samples = {s1, s0};
    start = 1'b1;
    tick();
    start = 1'b0;
    samples = 64'hDEAD_BEEF_0BAD_F00D;
    if (inject_drop) begin
      n = 0;
      while (words.size() == wbase && n < 100) begin tick(); n++; end
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("dropped_pulse", dropped, 1);
      tick();
      check_eq("dropped_clear", dropped, 0);
    end
    n = 0;
    while (frames == fbase && n < 400) begin tick(); n++; end
    check_eq("frames", frames, fbase + 1);
    check_eq("words_per_frame", words.size() - wbase, 2);
    check_eq("drops", drops - dbase, inject_drop ? 1 : 0);
    check_eq("ldac_low_clks", ldac_lows - lbase, LDAC_EXP);
    w0 = '0; w1 = '0;
    if (words.size() >= wbase + 2) begin
      w0 = words[wbase];
      w1 = words[wbase + 1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [23:0] w0, w1;
    int wb, fb, n;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_send", dac_send, 0);
    check_eq("rst_ldac", ldac, 1);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_dropped", dropped, 0);
    check_eq("rst_clip", clip, 0);
    check_eq("rst_data", dac_data, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_frame(32'h0, 32'h0, 1'b0, w0, w1);
    check_eq("zero_w0", w0, 24'h317FFF);
    check_eq("zero_w1", w1, 24'h327FFF);
    check_eq("zero_clip", clip, 2'b00);

    run_frame(32'hFFFE_0000, 32'h0002_0000, 1'b0, w0, w1);
    check_eq("neg_clamp_w0", w0, 24'h310000);
    check_eq("full_scale_w1", w1, 24'h32FFFF);
    check_eq("full_scale_clip", clip, 2'b00);

    run_frame(32'h0, 32'h0002_0001, 1'b0, w0, w1);
    check_eq("sat_w0", w0, 24'h317FFF);
    check_eq("sat_w1", w1, 24'h32FFFF);
    check_eq("sat_clip", clip, 2'b10);

    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    check_eq("clear_clip", clip, 2'b00);

    // Clear raised exactly in the ch1 convert cycle.
    wb = words.size(); fb = frames;
    wait_ready();
    samples = {32'h0002_0001, 32'h0};
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (words.size() == wb && n < 100) begin tick(); n++; end
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    check_eq("set_beats_clear", clip, 2'b10);
    tick();
    check_eq("clip_sticky", clip, 2'b10);
    n = 0;
    while (frames == fb && n < 400) begin tick(); n++; end
    check_eq("setclr_frames", frames, fb + 1);

    run_frame(32'h0, 32'h0, 1'b1, w0, w1);
    check_eq("drop_w0", w0, 24'h317FFF);
    check_eq("drop_w1", w1, 24'h327FFF);

    run_frame(32'h4, 32'hFFFF_FFFC, 1'b0, w0, w1);
    check_eq("after_drop_w0", w0, 24'h318000);
    check_eq("after_drop_w1", w1, 24'h327FFE);

    // Reset while ch1 is in its handshake.
    wb = words.size(); fb = frames;
    wait_ready();
    samples = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (words.size() < wb + 2 && n < 200) begin tick(); n++; end
    check_eq("ack_send", dac_send, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_send", dac_send, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_clip", clip, 2'b00);
    check_eq("async_ldac", ldac, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abandoned_frame", frames, fb);

    run_frame(32'h4, 32'hFFFF_FFFC, 1'b0, w0, w1);
    check_eq("post_rst_w0", w0, 24'h318000);
    check_eq("post_rst_w1", w1, 24'h327FFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
